mem_fabric: RTL and testbench
=============================

Name: mem_fabric

Overview:
Parametrised single-master memory-mapped interconnect. It sits between mem_bridge and the memory/peripheral controllers (RAM, serial, VGA, flash window) and generalises the fixed combinational address split into N_SLV decoded windows. Each transaction is a registered request/acknowledge handshake with a per-transaction timeout and an error response for unmapped or hung accesses. A saturating error counter is provided for debug LEDs.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
N_SLV, 4, number of slave ports
BASE, {16'hF000,16'h8000,16'hBF00,16'h0000}, packed N_SLV*ADDR_W window bases; slice i belongs to slave i
MASK, {16'hF000,16'hC000,16'hFFF0,16'h8000}, packed N_SLV*ADDR_W window masks
TIMEOUT, 255, maximum cycles spent in WAIT before an error response; minimum 1
DEFAULT_DATA, 16'hFFFF, m_rdata value returned on any error response

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
m_req  in  1  master request; sampled only in IDLE
m_we  in  1  1 = write, 0 = read
m_addr  in  ADDR_W  master address
m_wdata  in  DATA_W  master write data
m_rdata  out  DATA_W  read data; valid while m_ack is high
m_ack  out  1  one-cycle completion pulse
m_err  out  1  high together with m_ack when the access is unmapped or timed out
busy  out  1  high in WAIT and RESP
s_req  out  N_SLV  one-hot request, held until the selected slave acknowledges or the timeout fires
s_we  out  1  shared write flag
s_addr  out  ADDR_W  shared address
s_wdata  out  DATA_W  shared write data
s_rdata  in  N_SLV*DATA_W  packed slave read data
s_ack  in  N_SLV  slave acknowledge, one bit per slave
err_count  out  8  saturating count of error responses

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE. All of the following clear to 0: m_rdata, m_ack, m_err, busy, s_req, s_we, s_addr, s_wdata, err_count, and the timeout counter. A reset during WAIT drops s_req at that edge. No response is produced for the aborted transaction.
- Decode: slave i matches when (m_addr & MASK[i]) == BASE[i]. The lowest matching index wins. No match means unmapped.
- States: IDLE, WAIT, RESP.
- IDLE with m_req=1 at an edge:
  - latch m_we, m_addr and m_wdata onto s_we/s_addr/s_wdata;
  - mapped: set s_req[sel]=1, clear the timeout counter, go to WAIT;
  - unmapped: go to RESP with m_err=1, m_rdata=DEFAULT_DATA, err_count+1.
- IDLE with m_req=0: no change; m_ack=0.
- WAIT, at each edge:
  - s_ack[sel]=1: clear s_req, capture s_rdata slice sel into m_rdata (reads and writes alike), m_err=0, go to RESP;
  - otherwise, if counter == TIMEOUT-1: clear s_req, m_err=1, m_rdata=DEFAULT_DATA, err_count+1, go to RESP;
  - otherwise increment the counter.
  - If ack and timeout coincide, the ack wins.
  - Acks on non-selected s_ack bits are ignored in every state.
- RESP: m_ack=1 for exactly this one cycle, then IDLE at the next edge. m_req is not sampled in RESP; a request still high on return to IDLE is accepted as a new transaction.
- Latency:
  - mapped, slave acks on its first requested cycle: m_ack high in the 2nd cycle after m_req is sampled;
  - unmapped: m_ack high in the cycle immediately after sampling.
- s_addr/s_we/s_wdata are stable from acceptance until the next acceptance.
- err_count saturates at 255 and never wraps.
- busy = (state != IDLE).
- m_ack and m_err are registered outputs. s_req is registered and is never driven with more than one bit set.

Test Plan:
1. Reset then read 0x1234; slave0 acks on its 1st requested cycle with s_rdata[15:0]=0xBEEF -> s_req=4'b0001 for 1 cycle; m_ack=1 and m_rdata=0xBEEF in cycle 2; m_err=0.
2. Write 0xBF01 data 0x0041; slave1 acks after 3 cycles -> s_req=4'b0010 held 3 cycles, s_we=1, s_wdata=0x0041; one m_ack pulse; slave2 not requested despite 0xBF01 also matching its window.
3. Read 0xC123 (unmapped) -> no s_req bit set; m_ack=1 and m_err=1 in the next cycle; m_rdata=0xFFFF; err_count=1.
4. Read 0x9000 with TIMEOUT=4 and slave2 never acking -> s_req[2] high for exactly 4 cycles, then m_ack=1, m_err=1, m_rdata=0xFFFF; a stray s_ack[0] during the wait is ignored.
5. Same as 4, but s_ack[2] asserted on the 4th cycle -> ack wins: m_err=0, data captured, err_count unchanged.
6. rst asserted during WAIT -> s_req=0 and busy=0 after that edge, no m_ack, err_count=0. Separately, 300 unmapped reads -> err_count holds at 255.

Source files
------------

// File: rtl/mem_fabric.sv
// Single-master memory-mapped interconnect: decodes the master address into one
// of N_SLV windows and runs a registered req/ack handshake with a timeout.
module mem_fabric #(
  parameter int                     ADDR_W       = 16,
  parameter int                     DATA_W       = 16,
  parameter int                     N_SLV        = 4,
  parameter logic [N_SLV*ADDR_W-1:0] BASE        = {16'hF000, 16'h8000, 16'hBF00, 16'h0000},
  parameter logic [N_SLV*ADDR_W-1:0] MASK        = {16'hF000, 16'hC000, 16'hFFF0, 16'h8000},
  parameter int                     TIMEOUT      = 255,
  parameter logic [DATA_W-1:0]      DEFAULT_DATA = 16'hFFFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_req,
  input  logic                    m_we,
  input  logic [ADDR_W-1:0]       m_addr,
  input  logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W-1:0]       m_rdata,
  output logic                    m_ack,
  output logic                    m_err,
  output logic                    busy,
  output logic [N_SLV-1:0]        s_req,
  output logic                    s_we,
  output logic [ADDR_W-1:0]       s_addr,
  output logic [DATA_W-1:0]       s_wdata,
  input  logic [N_SLV*DATA_W-1:0] s_rdata,
  input  logic [N_SLV-1:0]        s_ack,
  output logic [7:0]              err_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  state_t              state_reg, state_next;
  logic [N_SLV-1:0]    s_req_reg, s_req_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   m_rdata_reg, m_rdata_next;
  logic                m_ack_reg, m_ack_next;
  logic                m_err_reg, m_err_next;
  logic                s_we_reg, s_we_next;
  logic [ADDR_W-1:0]   s_addr_reg, s_addr_next;
  logic [DATA_W-1:0]   s_wdata_reg, s_wdata_next;
  logic [7:0]          err_count_reg, err_count_next;

  logic [N_SLV-1:0]    hit;
  logic                hit_any;
  logic [SEL_W-1:0]    hit_idx;
  logic [DATA_W-1:0]   rdata_slice [N_SLV];
  logic [7:0]          err_count_inc;

  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_slv
    assign hit[gi] = (m_addr & MASK[gi*ADDR_W +: ADDR_W]) == BASE[gi*ADDR_W +: ADDR_W];
    assign rdata_slice[gi] = s_rdata[gi*DATA_W +: DATA_W];
  end

  // Descending scan so the lowest matching window overrides the others.
  always_comb begin
    hit_any = |hit;
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = SEL_W'(i);
    end
  end

  assign err_count_inc = (err_count_reg == 8'hFF) ? err_count_reg : err_count_reg + 8'd1;

  always_comb begin
    state_next     = state_reg;
    s_req_next     = s_req_reg;
    sel_next       = sel_reg;
    cnt_next       = cnt_reg;
    m_rdata_next   = m_rdata_reg;
    m_ack_next     = 1'b0;
    m_err_next     = 1'b0;
    s_we_next      = s_we_reg;
    s_addr_next    = s_addr_reg;
    s_wdata_next   = s_wdata_reg;
    err_count_next = err_count_reg;
    case (state_reg)
      IDLE: begin
        if (m_req) begin
          s_we_next    = m_we;
          s_addr_next  = m_addr;
          s_wdata_next = m_wdata;
          if (hit_any) begin
            s_req_next = N_SLV'(1) << hit_idx;
            sel_next   = hit_idx;
            cnt_next   = '0;
            state_next = WAIT;
          end else begin
            m_ack_next     = 1'b1;
            m_err_next     = 1'b1;
            m_rdata_next   = DEFAULT_DATA;
            err_count_next = err_count_inc;
            state_next     = RESP;
          end
        end
      end
      WAIT: begin
        // The acknowledge is checked first so it beats a coinciding timeout.
        if (s_ack[sel_reg]) begin
          s_req_next   = '0;
          m_rdata_next = rdata_slice[sel_reg];
          m_ack_next   = 1'b1;
          state_next   = RESP;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          s_req_next     = '0;
          m_ack_next     = 1'b1;
          m_err_next     = 1'b1;
          m_rdata_next   = DEFAULT_DATA;
          err_count_next = err_count_inc;
          state_next     = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      s_req_reg     <= '0;
      sel_reg       <= '0;
      cnt_reg       <= '0;
      m_rdata_reg   <= '0;
      m_ack_reg     <= 1'b0;
      m_err_reg     <= 1'b0;
      s_we_reg      <= 1'b0;
      s_addr_reg    <= '0;
      s_wdata_reg   <= '0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      s_req_reg     <= s_req_next;
      sel_reg       <= sel_next;
      cnt_reg       <= cnt_next;
      m_rdata_reg   <= m_rdata_next;
      m_ack_reg     <= m_ack_next;
      m_err_reg     <= m_err_next;
      s_we_reg      <= s_we_next;
      s_addr_reg    <= s_addr_next;
      s_wdata_reg   <= s_wdata_next;
      err_count_reg <= err_count_next;
    end
  end

  assign m_rdata   = m_rdata_reg;
  assign m_ack     = m_ack_reg;
  assign m_err     = m_err_reg;
  assign busy      = (state_reg != IDLE);
  assign s_req     = s_req_reg;
  assign s_we      = s_we_reg;
  assign s_addr    = s_addr_reg;
  assign s_wdata   = s_wdata_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_mem_fabric.sv
// Directed bench for mem_fabric: a table of transactions with hand-computed
// responses, plus reset-abort and error-counter saturation sequences.
module tb_mem_fabric;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_req;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_ack;
  logic        m_err;
  logic        busy;
  logic [3:0]  s_req;
  logic        s_we;
  logic [15:0] s_addr;
  logic [15:0] s_wdata;
  logic [63:0] s_rdata;
  logic [3:0]  s_ack;
  logic [7:0]  err_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_fabric #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
    .busy(busy), .s_req(s_req), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack), .err_count(err_count)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [3:0]  sel;       // expected one-hot s_req (0 = unmapped)
    int          delay;     // requested cycle on which the slave acks (0 = never)
    logic [3:0]  stray;     // acks driven on other bits while waiting
    logic [15:0] rdata;
    logic        exp_err;
    logic [15:0] exp_rdata;
    int          exp_req;   // cycles s_req is high
    int          exp_lat;   // negedge index after acceptance where m_ack is seen
  } vec_t;

  vec_t vecs [8];
  int   exp_err_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int       req_cyc = 0;
    int       lat = 0;
    logic     bad_req = 1'b0;
    logic     ack_busy = 1'b0;
    logic     got_err = 1'b0;
    logic [15:0] got_rdata = '0;
    for (int j = 0; j < 4; j++)
      s_rdata[j*16 +: 16] = v.sel[j] ? v.rdata : (16'hA500 | 16'(j));
    @(negedge clk);
    m_req = 1'b1; m_we = v.we; m_addr = v.addr; m_wdata = v.wdata; s_ack = '0;
    @(negedge clk);
    m_req = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (s_req != 4'b0) begin
        req_cyc++;
        if (s_req !== v.sel) bad_req = 1'b1;
      end
      if (m_ack === 1'b1) begin
        lat = cyc; ack_busy = busy; got_err = m_err; got_rdata = m_rdata;
        break;
      end
      s_ack = (v.delay != 0 && req_cyc == v.delay) ? v.sel : v.stray;
      @(negedge clk);
    end
    s_ack = '0;
    if (v.exp_err) exp_err_count++;
    check($sformatf("v%0d latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d req_cycles", idx), req_cyc, v.exp_req);
    check($sformatf("v%0d req_onehot", idx), bad_req, 1'b0);
    check($sformatf("v%0d m_err", idx), got_err, v.exp_err);
    check($sformatf("v%0d m_rdata", idx), got_rdata, v.exp_rdata);
    check($sformatf("v%0d s_we", idx), s_we, v.we);
    check($sformatf("v%0d s_addr", idx), s_addr, v.addr);
    check($sformatf("v%0d s_wdata", idx), s_wdata, v.wdata);
    check($sformatf("v%0d err_count", idx), err_count, exp_err_count);
    check($sformatf("v%0d busy_resp", idx), ack_busy, 1'b1);
    @(negedge clk);
    check($sformatf("v%0d ack_pulse", idx), m_ack, 1'b0);
    check($sformatf("v%0d busy_idle", idx), busy, 1'b0);
    $display("txn %0d: addr=%h we=%b lat=%0d req_cyc=%0d err=%b rdata=%h err_count=%0d",
             idx, v.addr, v.we, lat, req_cyc, got_err, got_rdata, err_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   acks;
    int   cnt_at_254;
    logic stray_ack;

    //         we    addr      wdata     sel      dly stray    rdata     err   exp_rdata req lat
    vecs[0] = '{1'b0, 16'h1234, 16'h0000, 4'b0001, 1, 4'b0000, 16'hBEEF, 1'b0, 16'hBEEF, 1, 2};
    vecs[1] = '{1'b1, 16'hBF01, 16'h0041, 4'b0010, 3, 4'b0000, 16'h1111, 1'b0, 16'h1111, 3, 4};
    vecs[2] = '{1'b0, 16'hC123, 16'h0000, 4'b0000, 0, 4'b0000, 16'h1357, 1'b1, 16'hFFFF, 0, 1};
    vecs[3] = '{1'b0, 16'h9000, 16'h0000, 4'b0100, 0, 4'b0001, 16'h2468, 1'b1, 16'hFFFF, 4, 5};
    vecs[4] = '{1'b0, 16'h9000, 16'h0000, 4'b0100, 4, 4'b1000, 16'h2222, 1'b0, 16'h2222, 4, 5};
    vecs[5] = '{1'b1, 16'hF00A, 16'hCAFE, 4'b1000, 2, 4'b0111, 16'h3333, 1'b0, 16'h3333, 2, 3};
    vecs[6] = '{1'b0, 16'h7FFF, 16'h0000, 4'b0001, 1, 4'b0000, 16'h4444, 1'b0, 16'h4444, 1, 2};
    vecs[7] = '{1'b0, 16'hBF10, 16'h0000, 4'b0100, 2, 4'b0010, 16'h5555, 1'b0, 16'h5555, 2, 3};

    rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    s_rdata = '0; s_ack = '0;
    repeat (3) @(negedge clk);
    check("rst m_ack", m_ack, 1'b0);
    check("rst m_err", m_err, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst s_req", s_req, 4'b0);
    check("rst err_count", err_count, 8'd0);
    check("rst m_rdata", m_rdata, 16'h0);
    check("rst s_bus", {s_we, s_addr, s_wdata}, 33'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset while a request is outstanding aborts it with no response.
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b0; m_addr = 16'h9000;
    @(negedge clk);
    m_req = 1'b0;
    check("abort s_req_before", s_req, 4'b0100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort s_req", s_req, 4'b0);
    check("abort busy", busy, 1'b0);
    check("abort m_ack", m_ack, 1'b0);
    check("abort err_count", err_count, 8'd0);
    stray_ack = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (m_ack) stray_ack = 1'b1;
    end
    check("abort no_ack", stray_ack, 1'b0);
    $display("txn abort: reset during WAIT, s_req=%b busy=%b err_count=%0d", s_req, busy, err_count);

    // Back-to-back unmapped reads with m_req held high: one per two cycles.
    acks = 0; cnt_at_254 = -1;
    m_req = 1'b1; m_addr = 16'hC000;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (m_ack) begin
        acks++;
        if (acks == 254) cnt_at_254 = int'(err_count);
      end
    end
    m_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (m_ack) acks++;
    end
    check("sat acks", acks, 300);
    check("sat count_254", cnt_at_254, 254);
    check("sat err_count", err_count, 8'd255);
    $display("txn saturate: %0d unmapped reads, err_count=%0d", acks, err_count);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
